peri_bus_router: RTL and testbench

PERI_BUS_ROUTER -- requirements
Module: peri_bus_router

---
 rtl/peri_bus_pkg.sv | 19 +
 rtl/peri_addr_decode.sv | 41 ++++
 rtl/peri_bus_router.sv | 142 ++++++++++++++
 tb/tb_peri_bus_router.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/peri_bus_pkg.sv
// Shared types and constants for the peripheral bus router.
package peri_bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF;
  localparam int          NUM_PERI_DEF   = 4;
  localparam logic [63:0] DEF_BASE_TABLE = {16'h1003, 16'h1002, 16'h1001, 16'h1000};

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/peri_addr_decode.sv
// Maps addr[31:16] to a priority-resolved one-hot port hit and its index;
// when windows overlap the lowest port index wins.
module peri_addr_decode
  import peri_bus_pkg::*;
#(
  parameter int                     NUM_PERI        = NUM_PERI_DEF,
  parameter logic [NUM_PERI*16-1:0] BASE_ADDR_TABLE = DEF_BASE_TABLE,
  localparam int                    IDX_W           = idx_width(NUM_PERI)
) (
  input  logic [15:0]         addr_hi,
  output logic [NUM_PERI-1:0] hit_vec,
  output logic                hit,
  output logic [IDX_W-1:0]    port_idx
);

  logic [NUM_PERI-1:0] match;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    match = '0;
    for (int p = 0; p < NUM_PERI; p++) begin
      match[p] = (addr_hi == BASE_ADDR_TABLE[p*16 +: 16]);
    end
  end

  // Scan from the top down so the lowest matching index is written last.
  always_comb begin
    hit_vec  = '0;
    port_idx = '0;
    for (int p = NUM_PERI - 1; p >= 0; p--) begin
      if (match[p]) begin
        hit_vec    = '0;
        hit_vec[p] = 1'b1;
        port_idx   = IDX_W'(p);
      end
    end
  end

  assign hit = |match;

endmodule

// File: rtl/peri_bus_router.sv
// Single-master to NUM_PERI-port bus router with IDLE/REQ/WAIT/RESP handshake.
// Optional WAIT-state timeout enabled by defining PERI_BUS_TIMEOUT_EN.
module peri_bus_router
  import peri_bus_pkg::*;
#(
  parameter int                     NUM_PERI        = NUM_PERI_DEF,
  parameter logic [NUM_PERI*16-1:0] BASE_ADDR_TABLE = DEF_BASE_TABLE,
  parameter int                     TIMEOUT_CYCLES  = 255
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     peri_rden_i,
  input  logic                     peri_wren_i,
  input  logic [31:0]              peri_addr_i,
  input  logic [31:0]              peri_wdata_i,
  input  logic [3:0]               peri_wstrb_i,
  output logic                     peri_ready_o,
  output logic [31:0]              peri_rdata_o,
  output logic                     peri_err_o,
  output logic [NUM_PERI*32-1:0]   addr_32b_o,
  output logic [NUM_PERI*32-1:0]   din_32b_o,
  output logic [NUM_PERI*4-1:0]    wstrb_o,
  output logic [NUM_PERI-1:0]      wren_o,
  output logic [NUM_PERI-1:0]      rden_o,
  input  logic [NUM_PERI-1:0]      dout_32b_valid_i,
  input  logic [NUM_PERI*32-1:0]   dout_32b_i
);

  localparam int IDX_W = idx_width(NUM_PERI);

  if (NUM_PERI < 1 || NUM_PERI > 16 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
    $error("peri_bus_router: parameter out of range");
  end

  state_e           state_q, state_d;
  logic [IDX_W-1:0] port_q;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [3:0]       wstrb_q;
  logic             write_q, err_q;

  logic [NUM_PERI-1:0] hit_vec;
  logic                hit;
  logic [IDX_W-1:0]    hit_idx;
  logic                req, port_valid, wait_done;

  peri_addr_decode #(
    .NUM_PERI        (NUM_PERI),
    .BASE_ADDR_TABLE (BASE_ADDR_TABLE)
  ) u_decode (
    .addr_hi  (peri_addr_i[31:16]),
    .hit_vec  (hit_vec),
    .hit      (hit),
    .port_idx (hit_idx)
  );

  assign req        = peri_rden_i | peri_wren_i;
  assign port_valid = dout_32b_valid_i[port_q];

`ifdef PERI_BUS_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                tmo_cnt_q <= '0;
    else if (state_q == ST_REQ)  tmo_cnt_q <= '0;
    else if (state_q == ST_WAIT) tmo_cnt_q <= tmo_cnt_q + 16'd1;
  end

  assign wait_done = port_valid || (tmo_cnt_q == TMO_LAST);
`else
  assign wait_done = port_valid;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (req) state_d = (|hit_vec) ? ST_REQ : ST_RESP;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: if (wait_done) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: the datapath registers are reset too, because rdata/err are visible outputs that must read 0.
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      port_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q <= state_d;
      if (state_q == ST_IDLE && req) begin
        port_q  <= hit_idx;
        addr_q  <= peri_addr_i;
        wdata_q <= peri_wdata_i;
        wstrb_q <= peri_wstrb_i;
        write_q <= peri_wren_i;
        if (!hit) begin
          rdata_q <= ERR_RDATA;
          err_q   <= 1'b1;
        end
      end
      if (state_q == ST_WAIT && wait_done) begin
        if (port_valid) begin
          rdata_q <= write_q ? 32'h0 : dout_32b_i[port_q*32 +: 32];
          err_q   <= 1'b0;
        end else begin
          rdata_q <= ERR_RDATA;
          err_q   <= 1'b1;
        end
      end
    end
  end

  // Port-side strobes and payload exist only in REQ, on the selected slice.
  always_comb begin
    addr_32b_o = '0;
    din_32b_o  = '0;
    wstrb_o    = '0;
    wren_o     = '0;
    rden_o     = '0;
    if (state_q == ST_REQ) begin
      addr_32b_o[port_q*32 +: 32] = addr_q;
      din_32b_o[port_q*32 +: 32]  = wdata_q;
      wstrb_o[port_q*4 +: 4]      = wstrb_q;
      if (write_q) wren_o[port_q] = 1'b1;
      else         rden_o[port_q] = 1'b1;
    end
  end

  assign peri_ready_o = (state_q == ST_RESP);
  assign peri_rdata_o = rdata_q;
  assign peri_err_o   = err_q;

endmodule

// File: tb/tb_peri_bus_router.sv
// Directed testbench for peri_bus_router (4 ports, default base table).
module tb_peri_bus_router;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         rden, wren;
  logic [31:0]  addr, wdata;
  logic [3:0]   wstrb;
  logic         ready, err;
  logic [31:0]  rdata;
  logic [127:0] p_addr, p_din, p_dout;
  logic [15:0]  p_wstrb;
  logic [3:0]   p_wren, p_rden, p_valid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  peri_bus_router #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .peri_rden_i      (rden),
    .peri_wren_i      (wren),
    .peri_addr_i      (addr),
    .peri_wdata_i     (wdata),
    .peri_wstrb_i     (wstrb),
    .peri_ready_o     (ready),
    .peri_rdata_o     (rdata),
    .peri_err_o       (err),
    .addr_32b_o       (p_addr),
    .din_32b_o        (p_din),
    .wstrb_o          (p_wstrb),
    .wren_o           (p_wren),
    .rden_o           (p_rden),
    .dout_32b_valid_i (p_valid),
    .dout_32b_i       (p_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    rden = rd; wren = wr; addr = a; wdata = d; wstrb = s;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rden = 0; wren = 0; addr = 0; wdata = 0; wstrb = 0;
    p_valid = 0; p_dout = 0;
    #3;
    total_cnt++;
    if ({ready, err, rdata, p_wren, p_rden, p_addr, p_din, p_wstrb} !== '0)
      $display("FAIL reset_outputs: got ready=%b err=%b rdata=%h wren=%b rden=%b want all 0",
               ready, err, rdata, p_wren, p_rden);
    else pass_cnt++;
    tick(); rst_n = 1'b1;
  endtask

  task automatic test_read();
    tick(); start(1, 0, 32'h1001_0004, 32'h0, 4'h0);
    total_cnt++;
    if ({ready, p_rden, p_wren} !== 9'h0) $display("FAIL rd_cycle0: got ready=%b rden=%b want 0", ready, p_rden);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (p_rden !== 4'b0010 || p_wren !== 4'b0000 || p_addr !== {64'h0, 32'h1001_0004, 32'h0})
      $display("FAIL rd_strobe: got rden=%b wren=%b addr=%h want rden=0010 slice1 addr", p_rden, p_wren, p_addr);
    else pass_cnt++;
    tick();
    p_valid = 4'b0010; p_dout = {64'h0, 32'hCAFE_0001, 32'h0};
    total_cnt++;
    if ({ready, p_rden} !== 5'h0) $display("FAIL rd_cycle2: got ready=%b rden=%b want 0", ready, p_rden);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ready !== 1'b1 || rdata !== 32'hCAFE_0001 || err !== 1'b0)
      $display("FAIL rd_resp: got ready=%b rdata=%h err=%b want 1 cafe0001 0", ready, rdata, err);
    else pass_cnt++;
    rden = 0; p_valid = 0; p_dout = 0;
    tick();
    total_cnt++;
    if (ready !== 1'b0 || rdata !== 32'hCAFE_0001)
      $display("FAIL rd_hold: got ready=%b rdata=%h want 0 cafe0001", ready, rdata);
    else pass_cnt++;
  endtask

  task automatic test_write();
    int wren_pulses = 0;
    int ready_pulses = 0;
    tick(); start(0, 1, 32'h1003_0000, 32'h55AA_55AA, 4'b0011);
    tick();
    wren_pulses += (p_wren != 0) ? 1 : 0;
    total_cnt++;
    if (p_wren !== 4'b1000 || p_rden !== 4'b0 || p_din !== {32'h55AA_55AA, 96'h0} ||
        p_wstrb !== 16'h3000 || p_addr !== {32'h1003_0000, 96'h0})
      $display("FAIL wr_strobe: got wren=%b din=%h wstrb=%h want 1000 slice3 3000", p_wren, p_din, p_wstrb);
    else pass_cnt++;
    for (int i = 0; i < 10; i++) begin
      tick();
      wren_pulses  += (p_wren != 0) ? 1 : 0;
      ready_pulses += ready ? 1 : 0;
    end
    p_valid = 4'b1000; p_dout = {32'h1234_5678, 96'h0};
    tick();
    ready_pulses += ready ? 1 : 0;
    total_cnt++;
    if (ready !== 1'b1 || rdata !== 32'h0 || err !== 1'b0)
      $display("FAIL wr_resp: got ready=%b rdata=%h err=%b want 1 0 0", ready, rdata, err);
    else pass_cnt++;
    wren = 0; p_valid = 0; p_dout = 0;
    tick();
    ready_pulses += ready ? 1 : 0;
    total_cnt++;
    if (wren_pulses != 1 || ready_pulses != 1)
      $display("FAIL wr_pulses: got wren=%0d ready=%0d want 1 1", wren_pulses, ready_pulses);
    else pass_cnt++;
  endtask

  task automatic test_decode_miss();
    tick(); start(1, 0, 32'h2000_0000, 32'h0, 4'h0);
    total_cnt++;
    if (ready !== 1'b0) $display("FAIL miss_cycle0: got ready=%b want 0", ready);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ready !== 1'b1 || err !== 1'b1 || rdata !== 32'hDEAD_BEEF || {p_rden, p_wren} !== 8'h0)
      $display("FAIL miss_resp: got ready=%b err=%b rdata=%h strobes=%b want 1 1 deadbeef 0",
               ready, err, rdata, {p_rden, p_wren});
    else pass_cnt++;
    rden = 0;
    tick();
  endtask

  task automatic test_reset_in_wait();
    int ready_pulses = 0;
    tick(); start(1, 0, 32'h1000_0000, 32'h0, 4'h0);
    tick(); tick();
    #2 rst_n = 1'b0; rden = 0;
    #1;
    total_cnt++;
    if ({ready, err, rdata, p_wren, p_rden, p_addr} !== '0)
      $display("FAIL rst_mid: got ready=%b err=%b rdata=%h want all 0", ready, err, rdata);
    else pass_cnt++;
    tick(); tick();
    rst_n = 1'b1;
    p_valid = 4'b0001; p_dout = {96'h0, 32'h0BAD_0BAD};
    for (int i = 0; i < 5; i++) begin
      tick();
      ready_pulses += ready ? 1 : 0;
    end
    total_cnt++;
    if (ready_pulses != 0 || {err, rdata, p_rden, p_wren} !== '0)
      $display("FAIL rst_abort: got ready_pulses=%0d err=%b rdata=%h want 0", ready_pulses, err, rdata);
    else pass_cnt++;
    p_valid = 0; p_dout = 0;
  endtask

  task automatic test_spurious_valid();
    tick(); start(1, 0, 32'h1000_0010, 32'h0, 4'h0);
    tick(); tick();
    p_valid = 4'b0100; p_dout = {32'h0, 32'hBAD0_0002, 64'h0};
    tick();
    total_cnt++;
    if (ready !== 1'b0) $display("FAIL spur_ignored: got ready=%b want 0", ready);
    else pass_cnt++;
    p_valid = 4'b0001; p_dout = {96'h0, 32'h0000_0A0A};
    tick();
    total_cnt++;
    if (ready !== 1'b1 || rdata !== 32'h0000_0A0A || err !== 1'b0)
      $display("FAIL spur_resp: got ready=%b rdata=%h err=%b want 1 00000a0a 0", ready, rdata, err);
    else pass_cnt++;
    rden = 0; p_valid = 0; p_dout = 0;
    tick();
  endtask

  task automatic test_rd_wr_both();
    tick(); start(1, 1, 32'h1002_0000, 32'hA5A5_0000, 4'hF);
    tick();
    total_cnt++;
    if (p_wren !== 4'b0100 || p_rden !== 4'b0000 || p_wstrb !== 16'h0F00)
      $display("FAIL both_is_write: got wren=%b rden=%b wstrb=%h want 0100 0000 0f00", p_wren, p_rden, p_wstrb);
    else pass_cnt++;
    tick();
    p_valid = 4'b0100;
    tick();
    rden = 0; wren = 0; p_valid = 0;
    tick();
  endtask

  task automatic test_back_to_back();
    tick(); start(1, 0, 32'h1002_0020, 32'h0, 4'h0);
    tick(); tick();
    p_valid = 4'b0100; p_dout = {32'h0, 32'h2222_0001, 64'h0};
    tick();
    p_valid = 0;
    total_cnt++;
    if (ready !== 1'b1 || rdata !== 32'h2222_0001)
      $display("FAIL b2b_first: got ready=%b rdata=%h want 1 22220001", ready, rdata);
    else pass_cnt++;
    tick();
    tick();
    total_cnt++;
    if (p_rden !== 4'b0100) $display("FAIL b2b_restart: got rden=%b want 0100", p_rden);
    else pass_cnt++;
    rden = 0;
    tick();
    p_valid = 4'b0100; p_dout = {32'h0, 32'h2222_0002, 64'h0};
    tick();
    p_valid = 0; p_dout = 0;
    total_cnt++;
    if (ready !== 1'b1 || rdata !== 32'h2222_0002)
      $display("FAIL b2b_second: got ready=%b rdata=%h want 1 22220002", ready, rdata);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_timeout();
    int ready_at = -1;
    tick(); start(1, 0, 32'h1000_0000, 32'h0, 4'h0);
    for (int c = 1; c <= 40 && ready_at < 0; c++) begin
      tick();
      if (ready) ready_at = c;
    end
`ifdef PERI_BUS_TIMEOUT_EN
    total_cnt++;
    if (ready_at != 10 || err !== 1'b1 || rdata !== 32'hDEAD_BEEF)
      $display("FAIL timeout_resp: got ready_cycle=%0d err=%b rdata=%h want 10 1 deadbeef", ready_at, err, rdata);
    else pass_cnt++;
    rden = 0;
    tick();
`else
    total_cnt++;
    if (ready_at != -1) $display("FAIL wait_persists: got ready at cycle %0d want none", ready_at);
    else pass_cnt++;
    rden = 0;
    p_valid = 4'b0001; p_dout = {96'h0, 32'h0000_7777};
    tick();
    p_valid = 0;
    total_cnt++;
    if (ready !== 1'b1 || rdata !== 32'h0000_7777)
      $display("FAIL wait_late_valid: got ready=%b rdata=%h want 1 00007777", ready, rdata);
    else pass_cnt++;
    tick();
`endif
    tick(); start(1, 0, 32'h1001_0008, 32'h0, 4'h0);
    tick(); tick();
    p_valid = 4'b0010; p_dout = {64'h0, 32'h1111_0008, 32'h0};
    tick();
    total_cnt++;
    if (ready !== 1'b1 || err !== 1'b0 || rdata !== 32'h1111_0008)
      $display("FAIL after_wait_read: got ready=%b err=%b rdata=%h want 1 0 11110008", ready, err, rdata);
    else pass_cnt++;
    rden = 0; p_valid = 0; p_dout = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_decode_miss();
    test_reset_in_wait();
    test_spurious_valid();
    test_rd_wr_both();
    test_back_to_back();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
